// File: rtl/baser_check_sequencer.sv
// baser_check_sequencer: run controller for the BASE-R 257b/66b receive checker chain
// Ports: clk/i_rst (async, active high); i_start/i_abort run control;
// i_pattern_mode/i_warmup_blocks/i_window_blocks run config latched on start;
// i_rx_valid block strobe; i_inv_count aggregated invalid-block count;
// o_chk_valid/o_chk_rst/o_pattern_mode drive the checkers; o_busy/o_done/o_pass/
// o_aborted/o_err_count/o_blocks_checked report status and results.
module baser_check_sequencer #(
  parameter int CNT_WIDTH    = 32,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [7:0]           i_pattern_mode,
  input  logic [CNT_WIDTH-1:0] i_warmup_blocks,
  input  logic [CNT_WIDTH-1:0] i_window_blocks,
  input  logic                 i_rx_valid,
  input  logic [CNT_WIDTH-1:0] i_inv_count,
  output logic                 o_chk_valid,
  output logic                 o_chk_rst,
  output logic [7:0]           o_pattern_mode,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_pass,
  output logic                 o_aborted,
  output logic [CNT_WIDTH-1:0] o_err_count,
  output logic [CNT_WIDTH-1:0] o_blocks_checked
);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, CLEAR, WARMUP, CHECK, DRAIN, DONE} state_t;
  state_t state, nxt;
  logic [CNT_WIDTH-1:0] warm_len, win_len, warm_cnt;
  logic [DW-1:0] drain_cnt;
  logic launch, abort, warm_last, chk_last, finish;
  assign launch    = state == IDLE && i_start;
  assign abort     = state != IDLE && i_abort;
  assign warm_last = i_rx_valid && warm_cnt == warm_len - ONE;
  assign chk_last  = i_rx_valid && o_blocks_checked == win_len - ONE;
  assign finish    = state == DRAIN && nxt == DONE;
  always_ff @(posedge clk or posedge i_rst)
    if (i_rst) state <= IDLE;
    else state <= nxt;
  // abort outranks every transition, including the DONE exit
  always_comb begin
    nxt = state;
    if (abort) nxt = IDLE;
    else
      case (state)
        IDLE:    nxt = i_start ? CLEAR : IDLE;
        CLEAR:   nxt = warm_len != '0 ? WARMUP : win_len != '0 ? CHECK : DRAIN;
        WARMUP:  nxt = !warm_last ? WARMUP : win_len != '0 ? CHECK : DRAIN;
        CHECK:   nxt = chk_last ? DRAIN : CHECK;
        DRAIN:   nxt = drain_cnt == DRAIN_LAST ? DONE : DRAIN;
        default: nxt = IDLE;
      endcase
  end
  always_comb begin
    o_busy      = state != IDLE;
    o_chk_valid = state == CHECK && i_rx_valid;
  end
  always_ff @(posedge clk or posedge i_rst)
    if (i_rst) begin
      o_chk_rst        <= 1'b0;
      o_pattern_mode   <= '0;
      o_done           <= 1'b0;
      o_pass           <= 1'b0;
      o_aborted        <= 1'b0;
      o_err_count      <= '0;
      o_blocks_checked <= '0;
      warm_len         <= '0;
      win_len          <= '0;
      warm_cnt         <= '0;
      drain_cnt        <= '0;
    end else begin
      o_chk_rst <= launch;
      o_done    <= finish;
      o_aborted <= abort;
      if (launch) begin
        o_pattern_mode   <= i_pattern_mode;
        warm_len         <= i_warmup_blocks;
        win_len          <= i_window_blocks;
        o_blocks_checked <= '0;
        o_pass           <= 1'b0;
        o_err_count      <= '0;
        warm_cnt         <= '0;
        drain_cnt        <= '0;
      end
      if (state == WARMUP && i_rx_valid && warm_cnt != CNT_MAX) warm_cnt <= warm_cnt + ONE;
      if (o_chk_valid && o_blocks_checked != CNT_MAX) o_blocks_checked <= o_blocks_checked + ONE;
      if (state == DRAIN) drain_cnt <= drain_cnt + DW'(1);
      // results land together with the registered done pulse
      if (finish) begin
        o_err_count <= i_inv_count;
        o_pass      <= i_inv_count == '0;
      end
      if (abort) o_pass <= 1'b0;
    end
endmodule

// File: doc/baser_check_sequencer.md
# baser_check_sequencer

Run controller for the BASE-R receive checker chain: the 257b transcoded-block checker feeding four 66b lane checkers. On a start request it clears the checkers, skips a programmable warm-up of blocks while the PRBS/pattern checkers self-synchronise, and gates the checker valid for a fixed measurement window. It then waits for the checker pipelines to settle, samples the aggregated invalid-block count, and reports pass/fail through a done pulse. It sits between the test-control registers and the checkers' `i_valid` / `i_rst` / `i_pattern_mode` inputs.

## Interface
Parameters:
- `CNT_WIDTH`, 32: width of block counters, window/warm-up lengths and error count.
- `DRAIN_CYCLES`, 2: idle cycles after the last checked block before sampling counters (must be ≥1).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_start`  in  1  single-cycle start request; honoured only in IDLE.
- `i_abort`  in  1  abort request; honoured in any non-IDLE state.
- `i_pattern_mode`  in  8  pattern selection for the run (0 = fixed chars, 2 = PRBS8, …).
- `i_warmup_blocks`  in  CNT_WIDTH  blocks to skip before checking.
- `i_window_blocks`  in  CNT_WIDTH  blocks to check.
- `i_rx_valid`  in  1  a new 257b block is presented to the checker this cycle.
- `i_inv_count`  in  CNT_WIDTH  sum of the 257b and four 66b invalid-block counters.
- `o_chk_valid`  out  1  checker enable: `i_rx_valid` gated by state CHECK (combinational).
- `o_chk_rst`  out  1  registered checker counter clear; high for exactly one cycle.
- `o_pattern_mode`  out  8  latched pattern mode driven to the checkers.
- `o_busy`  out  1  high in every state except IDLE.
- `o_done`  out  1  one-cycle completion pulse.
- `o_pass`  out  1  result; valid from `o_done` until next start.
- `o_aborted`  out  1  one-cycle pulse on abort.
- `o_err_count`  out  CNT_WIDTH  latched `i_inv_count` at completion.
- `o_blocks_checked`  out  CNT_WIDTH  blocks enabled during CHECK (live, then held).

## Operation
- States: IDLE, CLEAR, WARMUP, CHECK, DRAIN, DONE.
- IDLE: `i_start`=1 latches `i_pattern_mode`, `i_warmup_blocks`, `i_window_blocks`; clears `o_blocks_checked`, `o_pass`, `o_err_count`; goes to CLEAR.
- CLEAR: one cycle; `o_chk_rst`=1. Next state is WARMUP if warm-up ≠0, else CHECK if window ≠0, else DRAIN.
- WARMUP: each `i_rx_valid` increments the warm-up counter. When the count reaches warm-up−1 with `i_rx_valid`=1, go to CHECK, or to DRAIN if window=0. `o_chk_valid`=0.
- CHECK: `o_chk_valid`=`i_rx_valid`. Each valid increments `o_blocks_checked`. The valid that makes it equal to window moves to DRAIN.
- DRAIN: counts `DRAIN_CYCLES` cycles with `o_chk_valid`=0, then goes to DONE.
- DONE: one cycle. `o_err_count`←`i_inv_count`; `o_pass`←(`i_inv_count`==0); `o_done`=1 (registered, same cycle as the latched values appearing). Then IDLE.
- Abort: `i_abort`=1 in CLEAR..DONE forces IDLE next cycle with an `o_aborted` pulse and no `o_done`. `o_pass` stays 0. Abort has priority over every other transition, including the DONE exit.
- `i_start` while busy and `i_abort` in IDLE are ignored.
- Counters saturate at all-ones; they never wrap.
- `o_pattern_mode` holds its latched value in IDLE after the run.

## Timing
- Reset values: all outputs 0, state IDLE, internal counters 0, `o_pattern_mode`=0.
- `i_start` at cycle t: `o_busy`=1 and `o_chk_rst`=1 at t+1.
- The first block seen by the checker is the (W+1)-th `i_rx_valid` after CLEAR, where W is the warm-up count.
- Last checked valid at cycle c: DRAIN spans c+1..c+DRAIN_CYCLES; `o_done` at c+DRAIN_CYCLES+1; `o_busy` low at c+DRAIN_CYCLES+2.
- Reset mid-run: immediate IDLE, no `o_done`/`o_aborted`.

## Test plan
- Warm-up 4, window 10, valid every cycle, `i_inv_count`=0 → `o_chk_valid` high exactly 10 cycles starting 5 cycles after CLEAR; `o_blocks_checked`=10; `o_done` 3 cycles after the last check (DRAIN_CYCLES=2); `o_pass`=1.
- Same run with `i_inv_count`=7 at DONE → `o_err_count`=7, `o_pass`=0.
- `i_rx_valid` every third cycle, warm-up 2, window 3 → exactly 3 `o_chk_valid` pulses, aligned with the 3rd, 4th and 5th valids.
- Warm-up 0, window 0 → CLEAR→DRAIN→DONE, `o_done` 4 cycles after start, `o_blocks_checked`=0, `o_pass`=1 if `i_inv_count`=0.
- `i_abort` mid-CHECK → `o_aborted` pulse, IDLE next cycle, no `o_done`. A second `i_start` during the run has no effect.
- `i_rst` asserted asynchronously mid-WARMUP → all outputs 0 without a clock edge. A later start runs normally.
